// File: rtl/ushift_reg_n_if.sv
// Bus bundle for ushift_reg_n: mode/data/burst controls in, register and status out.
interface ushift_reg_n_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
);
  logic             OE;
  logic [2:0]       S;
  logic [WIDTH-1:0] D;
  logic             SRI;
  logic             SLI;
  logic             START;
  logic [CW-1:0]    CNT;
  logic [WIDTH-1:0] Q;
  logic             SO_R;
  logic             SO_L;
  logic             BUSY;
  logic             DONE;

  modport master (
    output OE, S, D, SRI, SLI, START, CNT,
    input  Q, SO_R, SO_L, BUSY, DONE
  );

  modport slave (
    input  OE, S, D, SRI, SLI, START, CNT,
    output Q, SO_R, SO_L, BUSY, DONE
  );
endinterface

// File: rtl/ushift_reg_n.sv
// Parametrised universal shift register with counted burst-shift engine.
// Optional macro USHIFT_TRISTATE_EN: Q floats when OE=1 (otherwise Q is forced to zero).
module ushift_reg_n #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input logic         CLK,
  input logic         RST,
  ushift_reg_n_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]       state;
  logic [2:0]       mode_p0;
  logic [CW-1:0]    rem_p0;
  logic [WIDTH-1:0] r_p0;
  logic             done_p0;

  function automatic logic [WIDTH-1:0] shift_op(
    input logic [2:0]       mode,
    input logic [WIDTH-1:0] r,
    input logic [WIDTH-1:0] d,
    input logic             sri,
    input logic             sli
  );
    case (mode)
      3'b001:  shift_op = {sri, r[WIDTH-1:1]};
      3'b010:  shift_op = {r[WIDTH-2:0], sli};
      3'b011:  shift_op = d;
      3'b100:  shift_op = {r[0], r[WIDTH-1:1]};
      3'b101:  shift_op = {r[WIDTH-2:0], r[WIDTH-1]};
      3'b110:  shift_op = {r[WIDTH-1], r[WIDTH-1:1]};
      default: shift_op = r;
    endcase
  endfunction

  // Only real shift/rotate modes can start a burst; hold and load cannot.
  function automatic logic is_burst_mode(input logic [2:0] mode);
    is_burst_mode = (mode == 3'b001) || (mode == 3'b010) || (mode == 3'b100) ||
                    (mode == 3'b101) || (mode == 3'b110);
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      mode_p0 <= 3'b000;
      rem_p0  <= '0;
      r_p0    <= '0;
      done_p0 <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_p0 <= 1'b0;
          if (bus.START && is_burst_mode(bus.S)) begin
            mode_p0 <= bus.S;
            rem_p0  <= bus.CNT;
            if (bus.CNT == '0) done_p0 <= 1'b1;
            else               state   <= ST_BURST;
          end else begin
            r_p0 <= shift_op(bus.S, r_p0, bus.D, bus.SRI, bus.SLI);
          end
        end
        default: begin
          r_p0   <= shift_op(mode_p0, r_p0, bus.D, bus.SRI, bus.SLI);
          rem_p0 <= rem_p0 - CW'(1);
          if (rem_p0 == CW'(1)) begin
            state   <= ST_IDLE;
            done_p0 <= 1'b1;
          end else begin
            done_p0 <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.BUSY = (state == ST_BURST);
  assign bus.DONE = done_p0;
  assign bus.SO_R = r_p0[0];
  assign bus.SO_L = r_p0[WIDTH-1];

`ifdef USHIFT_TRISTATE_EN
  assign bus.Q = bus.OE ? {WIDTH{1'bz}} : r_p0;
`else
  assign bus.Q = bus.OE ? {WIDTH{1'b0}} : r_p0;
`endif

endmodule

// File: tb/tb_ushift_reg_n.sv
// Randomised and directed bench for ushift_reg_n against a behavioural reference.
module tb_ushift_reg_n;
  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic CLK;
  logic RST;
  int   checks;
  int   failures;

  ushift_reg_n_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  ushift_reg_n #(.WIDTH(WIDTH), .CW(CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference state: register value, shifts still owed by a burst, burst mode, done flag.
  logic [WIDTH-1:0] m_r;
  int               m_left;
  logic [2:0]       m_mode;
  logic             m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] mode, input logic [WIDTH-1:0] r,
                                              input logic [WIDTH-1:0] d, input logic sri,
                                              input logic sli);
    int v;
    int msb;
    v   = int'(r);
    msb = (v >> (WIDTH - 1)) & 1;
    case (mode)
      3'd1: v = (v >> 1) + (int'(sri) << (WIDTH - 1));
      3'd2: v = ((v << 1) & ((1 << WIDTH) - 1)) + int'(sli);
      3'd3: v = int'(d);
      3'd4: v = (v >> 1) + ((v & 1) << (WIDTH - 1));
      3'd5: v = ((v << 1) & ((1 << WIDTH) - 1)) + msb;
      3'd6: v = (v >> 1) + (msb << (WIDTH - 1));
      default: ;
    endcase
    return v[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] exp_q();
`ifdef USHIFT_TRISTATE_EN
    return bus.OE ? {WIDTH{1'bz}} : m_r;
`else
    return bus.OE ? {WIDTH{1'b0}} : m_r;
`endif
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".Q"},    32'(bus.Q),    32'(exp_q()));
    chk({tag, ".BUSY"}, 32'(bus.BUSY), 32'(m_left > 0));
    chk({tag, ".DONE"}, 32'(bus.DONE), 32'(m_done));
    chk({tag, ".SO_R"}, 32'(bus.SO_R), 32'(m_r[0]));
    chk({tag, ".SO_L"}, 32'(bus.SO_L), 32'(m_r[WIDTH-1]));
  endtask

  // Advance the reference using the inputs present before the edge, then clock and compare.
  task automatic step(input string tag);
    if (RST) begin
      m_r = '0; m_left = 0; m_done = 1'b0;
    end else if (m_left > 0) begin
      m_r    = ref_op(m_mode, m_r, bus.D, bus.SRI, bus.SLI);
      m_left = m_left - 1;
      m_done = (m_left == 0);
    end else begin
      m_done = 1'b0;
      if (bus.START && (bus.S inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6})) begin
        m_mode = bus.S;
        m_left = int'(bus.CNT);
        m_done = (bus.CNT == 0);
      end else begin
        m_r = ref_op(bus.S, m_r, bus.D, bus.SRI, bus.SLI);
      end
    end
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  initial begin
    checks = 0; failures = 0;
    m_r = '0; m_left = 0; m_mode = 3'd0; m_done = 1'b0;
    RST = 1'b1; bus.OE = 1'b0; bus.S = 3'd0; bus.D = '0; bus.SRI = 1'b0; bus.SLI = 1'b0;
    bus.START = 1'b0; bus.CNT = '0;

    step("reset");
    chk("reset_q", 32'(bus.Q), 32'h00);
    RST = 1'b0;
    bus.S = 3'd3; bus.D = 8'hA5; step("load");
    chk("load_a5", 32'(bus.Q), 32'hA5);
    bus.S = 3'd1; bus.SRI = 1'b1; step("shr");
    chk("shr_d2", 32'(bus.Q), 32'hD2);
    bus.S = 3'd2; bus.SLI = 1'b0; step("shl");
    chk("shl_a4", 32'(bus.Q), 32'hA4);
    bus.S = 3'd3; bus.D = 8'h80; step("load80");
    bus.S = 3'd6; step("asr");
    chk("asr_c0", 32'(bus.Q), 32'hC0);

    // Rotate-right burst of 3 while S is scrambled
    bus.S = 3'd3; bus.D = 8'h81; step("load81");
    bus.START = 1'b1; bus.S = 3'd4; bus.CNT = 4'd3; step("rot_accept");
    chk("rot_busy", 32'(bus.BUSY), 32'd1);
    bus.START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.S = 3'($urandom_range(0, 7)); bus.D = 8'($urandom);
      step("rot_burst");
    end
    chk("rot_q30", 32'(bus.Q), 32'h30);
    chk("rot_done", 32'(bus.DONE), 32'd1);
    bus.S = 3'd0; step("rot_after");
    chk("rot_done_drop", 32'(bus.DONE), 32'd0);

    // Zero-length burst and START with a non-shift mode
    bus.START = 1'b1; bus.S = 3'd5; bus.CNT = 4'd0; step("cnt0");
    chk("cnt0_done", 32'(bus.DONE), 32'd1);
    chk("cnt0_q", 32'(bus.Q), 32'h30);
    bus.S = 3'd3; bus.D = 8'h5A; step("start_load");
    chk("start_load_q", 32'(bus.Q), 32'h5A);
    chk("start_load_done", 32'(bus.DONE), 32'd0);
    bus.START = 1'b0;

    // Long burst cut short by reset
    bus.S = 3'd3; bus.D = 8'hFF; step("loadff");
    bus.START = 1'b1; bus.S = 3'd2; bus.SLI = 1'b0; bus.CNT = 4'd10; step("long_accept");
    bus.START = 1'b0;
    for (int i = 0; i < 4; i++) step("long_burst");
    chk("long_q_f0", 32'(bus.Q), 32'hF0);
    RST = 1'b1; step("mid_rst");
    chk("mid_rst_busy", 32'(bus.BUSY), 32'd0);
    RST = 1'b0; bus.S = 3'd0; step("post_rst");
    chk("post_rst_done", 32'(bus.DONE), 32'd0);

    // Output enable is combinational
    bus.S = 3'd3; bus.D = 8'h3C; step("load3c");
    bus.S = 3'd0; bus.OE = 1'b1; #1;
`ifdef USHIFT_TRISTATE_EN
    chk("oe_off_q", 32'(bus.Q), 32'(8'bzzzzzzzz));
`else
    chk("oe_off_q", 32'(bus.Q), 32'h00);
`endif
    chk("oe_so_l", 32'(bus.SO_L), 32'd0);
    chk("oe_so_r", 32'(bus.SO_R), 32'd0);
    bus.OE = 1'b0; #1;
    chk("oe_on_q", 32'(bus.Q), 32'h3C);

    for (int i = 0; i < 600; i++) begin
      RST       = ($urandom_range(0, 60) == 0);
      bus.OE    = ($urandom_range(0, 7) == 0);
      bus.S     = 3'($urandom_range(0, 7));
      bus.D     = 8'($urandom);
      bus.SRI   = 1'($urandom);
      bus.SLI   = 1'($urandom);
      bus.START = ($urandom_range(0, 3) == 0);
      bus.CNT   = 4'($urandom_range(0, 15));
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
